audio_arbiter: RTL

// - Shares the single DE1 audio codec write path between the background music generator and the one-shot sound effects.
// - Sources are music (src 0, continuous) and shoot, enemy-hit and player-death (srcs 1..3, timed one-shots).
// - Tracks active sources, grants the codec to the highest-priority one and drives the en of each generator.
// - Forwards the granted 24-bit sample to the codec, one write per write_ready.

---
 rtl/audio_pkg.sv | 17 +
 rtl/audio_arbiter_sfx_timer.sv | 30 +++
 rtl/audio_arbiter.sv | 87 ++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared types and default sizing for the audio codec arbiter slice.
package audio_pkg;

    localparam int unsigned NUM_SRC = 4;
    localparam int unsigned W       = 24;
    localparam int unsigned SFX_DUR = 5000000;

    typedef logic signed [W-1:0] sample_t;

    typedef enum logic [1:0] {
        SRC_MUSIC,
        SRC_SHOOT,
        SRC_HIT,
        SRC_DEATH
    } src_e;

endpackage

// File: rtl/audio_arbiter_sfx_timer.sv
// One-shot activity timer: a start pulse (re)loads DUR-1 and holds active for DUR cycles.
module sfx_timer #(
    parameter int unsigned DUR = 5000000
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic active
);

    localparam int unsigned TW = (DUR > 1) ? $clog2(DUR) : 1;

    logic [TW-1:0] timer;

    // A start wins over expiry so a retrigger on the last cycle leaves no gap.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer  <= '0;
            active <= 1'b0;
        end else if (start) begin
            timer  <= TW'(DUR - 1);
            active <= 1'b1;
        end else if (timer != '0) begin
            timer  <= timer - TW'(1);
        end else begin
            active <= 1'b0;
        end
    end

endmodule

// File: rtl/audio_arbiter.sv
// Fixed-priority arbiter sharing the codec write path between music and one-shot effects.
module audio_arbiter #(
    parameter int unsigned NUM_SRC = audio_pkg::NUM_SRC,
    parameter int unsigned SFX_DUR = audio_pkg::SFX_DUR,
    parameter int unsigned W       = audio_pkg::W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         music_on,
    input  logic [NUM_SRC-1:0]           sfx_req,
    input  logic                         mute,
    input  logic [NUM_SRC*W-1:0]         src_sample,
    input  logic                         write_ready,
    output logic [NUM_SRC-1:0]           src_en,
    output logic [$clog2(NUM_SRC)-1:0]   grant,
    output logic                         grant_valid,
    output logic                         write,
    output logic [W-1:0]                 sample_left,
    output logic [W-1:0]                 sample_right
);

    import audio_pkg::*;

    localparam int unsigned GW = $clog2(NUM_SRC);

    logic                 music_active;
    logic [NUM_SRC-1:1]   sfx_active;
    logic [NUM_SRC-1:0]   active;
    logic [W-1:0]         samples [NUM_SRC];
    logic [GW-1:0]        grant_nxt;
    logic                 valid_nxt;
    logic                 take_sample;

    // Music is not a one-shot, so its request bit carries no meaning.
    logic unused_sfx0;
    assign unused_sfx0 = sfx_req[0];

    for (genvar i = 1; i < NUM_SRC; i++) begin : g_sfx
        sfx_timer #(.DUR(SFX_DUR)) u_timer (
            .clk    (clk),
            .reset  (reset),
            .start  (sfx_req[i]),
            .active (sfx_active[i])
        );
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
        assign samples[i] = src_sample[i*W +: W];
    end

    assign active      = {sfx_active, music_active};
    assign take_sample = write_ready && !write;

    // Highest active index wins; grant holds when nothing is active.
    always_comb begin
        grant_nxt = grant;
        valid_nxt = |active;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (active[i]) begin
                grant_nxt = GW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            music_active <= 1'b0;
            grant        <= '0;
            grant_valid  <= 1'b0;
            src_en       <= '0;
            write        <= 1'b0;
            sample_left  <= '0;
            sample_right <= '0;
        end else begin
            music_active <= music_on;
            grant        <= grant_nxt;
            grant_valid  <= valid_nxt;
            src_en       <= valid_nxt ? (NUM_SRC'(1) << grant_nxt) : '0;
            write        <= take_sample;
            if (take_sample) begin
                sample_left  <= (grant_valid && !mute) ? samples[grant] : '0;
                sample_right <= (grant_valid && !mute) ? samples[grant] : '0;
            end
        end
    end

endmodule
